elbeth_load_store_unit: RTL and testbench
=========================================

// Module: elbeth_load_store_unit
// PURPOSE
//  Data-memory access stage downstream of the EXS stage. Takes one load/store request per
//  instruction and converts it to a word-aligned data-memory transaction with byte enables.
//  Waits for the memory handshake and returns sign/zero-extended load data.
//  Drives exs_mem_ready, which the control unit uses to stall the pipeline.
// PARAMETERS
//  TIMEOUT_CYCLES  255  WAIT cycles without dmem_ready before the access is aborted with a fault
//  TIMEOUT_W       8    width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk              in   1   single clock; all state updates on rising edge
//  rst              in   1   asynchronous, active-low reset
//  exs_mem_en       in   1   EXS requests a memory access this cycle
//  exs_mem_write    in   1   1=store, 0=load
//  exs_data_size    in   2   00=byte, 01=half, 10=word; 11 is illegal and raises a fault
//  exs_data_sign    in   1   1=sign-extend load, 0=zero-extend
//  exs_addr         in   32  byte address (ALU result)
//  exs_w_data       in   32  store data (rs2), right-justified
//  exs_mem_ready    out  1   access complete / no access pending; 0 => pipeline stalls
//  exs_load_data    out  32  extended load data; valid while exs_mem_ready=1 in DONE
//  exs_mem_fault    out  1   misaligned, illegal-size or timed-out access; 1-cycle pulse
//  dmem_req         out  1   memory request valid
//  dmem_we          out  1   write strobe, qualified by dmem_req
//  dmem_addr        out  32  word address {addr[31:2],2'b00}
//  dmem_byte_en     out  4   active byte lanes
//  dmem_w_data      out  32  store data replicated/shifted into the active lanes
//  dmem_r_data      in   32  read word, valid when dmem_ready=1
//  dmem_ready       in   1   memory completes the request this cycle
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0, and all dmem_* outputs and registered data = 0.
//   exs_mem_fault=0 and exs_mem_ready=1. An in-flight access is abandoned; no fault is reported.
//  FSM IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: exs_mem_ready = !exs_mem_en.
//   On exs_mem_en=1 with a legal size and alignment: register addr, we, byte_en, shifted wdata,
//   size and sign; clear counter; go to WAIT.
//   Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11: exs_mem_fault=1 and
//   exs_mem_ready=1 in the same cycle. No dmem_req is issued and state stays IDLE.
//  WAIT: dmem_req=1. addr, we, byte_en and w_data are held stable, exs_mem_ready=0.
//   On dmem_ready=1: capture dmem_r_data into the load register and go to DONE. A store still
//   goes through DONE.
//   Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 and dmem_ready=0: pulse
//   exs_mem_fault in DONE, load data=0, go to DONE. dmem_ready on the same cycle wins over
//   the timeout.
//  DONE: exs_mem_ready=1 and dmem_req=0 for exactly one cycle. exs_mem_en is ignored. Next
//   state is IDLE, so back-to-back requests cost at least 3 cycles each.
//  Latency: request at cycle 0, dmem_req from cycle 1; dmem_ready at cycle 1 => ready at cycle 2.
//  Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
//   w_data is byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  Load: select lane by registered a[1:0]; extend from bit 7/15 per the registered sign.
//   Word loads are passed through unchanged.
//  Memory must ignore dmem_we when dmem_req=0. Only one request is ever outstanding.
// STRUCTURE
//  elbeth_pkg: size encodings (SIZE_B/H/W), FSM state localparams (2-bit), and the
//   default TIMEOUT_CYCLES.
//  Sub-module elbeth_load_extend: combinational lane select plus sign/zero extension
//   (in: word, a[1:0], size, sign; out: 32-bit).
// TESTING
//  LW at 0x100, mem returns 0xDEADBEEF with dmem_ready in cycle 1:
//   -> byte_en=1111, ready at cycle 2, load=0xDEADBEEF.
//  LB signed at 0x103, word 0x80FF_0000:
//   -> byte_en=1000, load=0xFFFF_FF80. The same access as LBU -> 0x0000_0080.
//  SH at 0x202, data 0x1234ABCD:
//   -> dmem_we=1, byte_en=1100, w_data=0xABCDABCD, addr=0x200.
//  LW at 0x101:
//   -> fault=1 and ready=1 in the same cycle, dmem_req never asserted.
//  dmem_ready held 0, TIMEOUT_CYCLES=4:
//   -> dmem_req high 4 cycles, then DONE with fault=1 and load=0.
//  Assert rst mid-WAIT:
//   -> dmem_req=0 immediately (async), ready=1, no fault; a new LW then completes normally.

Source files
------------

// File: rtl/elbeth_pkg.sv
// Shared encodings and helpers for the elbeth load/store unit.
// Size codes, FSM states, timeout default and lane helpers.
package elbeth_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic illegal_acc(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (sz == SIZE_B): r = 1'b0;
      (sz == SIZE_H): r = a[0];
      (sz == SIZE_W): r = (a != 2'b00);
      default:        r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_en(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [3:0] r;
    r = 4'b1111;
    unique case (1'b1)
      (sz == SIZE_B): r = 4'b0001 << a;
      (sz == SIZE_H): r = 4'b0011 << a;
      default:        r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = d;
    unique case (1'b1)
      (sz == SIZE_B): r = {4{d[7:0]}};
      (sz == SIZE_H): r = {2{d[15:0]}};
      default:        r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elbeth_load_extend.sv
// Load lane select and sign/zero extension.
// Purely combinational; word loads pass through.
module elbeth_load_extend
  import elbeth_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_a,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b = i_word[7:0];
    unique case (i_a)
      2'd0: w_b = i_word[7:0];
      2'd1: w_b = i_word[15:8];
      2'd2: w_b = i_word[23:16];
      2'd3: w_b = i_word[31:24];
      default: w_b = i_word[7:0];
    endcase
  end

  assign w_h = i_a[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    unique case (1'b1)
      (i_size == SIZE_B):
        o_data = {{24{i_sign & w_b[7]}}, w_b};
      (i_size == SIZE_H):
        o_data = {{16{i_sign & w_h[15]}}, w_h};
      default:
        o_data = i_word;
    endcase
  end

endmodule

// File: rtl/elbeth_load_store_unit.sv
// Data-memory access stage: aligns requests, waits on dmem,
// and returns extended load data with stall/fault signalling.
module elbeth_load_store_unit
  import elbeth_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exs_mem_en,
  input  logic        exs_mem_write,
  input  logic [1:0]  exs_data_size,
  input  logic        exs_data_sign,
  input  logic [31:0] exs_addr,
  input  logic [31:0] exs_w_data,
  output logic        exs_mem_ready,
  output logic [31:0] exs_load_data,
  output logic        exs_mem_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_byte_en,
  output logic [31:0] dmem_w_data,
  input  logic [31:0] dmem_r_data,
  input  logic        dmem_ready
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic [TIMEOUT_W-1:0] r_cnt;
  logic [31:0]          r_addr;
  logic                 r_we;
  logic [3:0]           r_be;
  logic [31:0]          r_wdata;
  logic [1:0]           r_size;
  logic                 r_sign;
  logic [31:0]          r_rdata;
  logic                 r_to;

  logic        w_illegal;
  logic        w_accept;
  logic        w_last;
  logic [31:0] w_ext;

  assign w_illegal = illegal_acc(exs_data_size, exs_addr[1:0]);
  assign w_accept  = (r_state == ST_IDLE) & exs_mem_en & ~w_illegal;
  assign w_last    = (r_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_WAIT;
      ST_WAIT: if (dmem_ready | w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_sign  <= 1'b0;
      r_rdata <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= exs_addr;
            r_we    <= exs_mem_write;
            r_be    <= lane_en(exs_data_size, exs_addr[1:0]);
            r_wdata <= lane_data(exs_data_size, exs_w_data);
            r_size  <= exs_data_size;
            r_sign  <= exs_data_sign;
            r_cnt   <= '0;
            r_to    <= 1'b0;
          end
        end
        ST_WAIT: begin
          // a completing handshake beats the timeout on the same cycle
          if (dmem_ready) begin
            r_rdata <= dmem_r_data;
          end else if (w_last) begin
            r_rdata <= '0;
            r_to    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
          end
        end
        ST_DONE: r_to <= 1'b0;
        default: r_to <= 1'b0;
      endcase
    end
  end

  elbeth_load_extend u_ext (
    .i_word (r_rdata),
    .i_a    (r_addr[1:0]),
    .i_size (r_size),
    .i_sign (r_sign),
    .o_data (w_ext)
  );

  always_comb begin
    exs_mem_ready = 1'b0;
    exs_mem_fault = 1'b0;
    exs_load_data = '0;
    unique case (r_state)
      ST_IDLE: begin
        exs_mem_ready = ~exs_mem_en | w_illegal;
        exs_mem_fault = exs_mem_en & w_illegal;
      end
      ST_WAIT: exs_mem_ready = 1'b0;
      ST_DONE: begin
        exs_mem_ready = 1'b1;
        exs_mem_fault = r_to;
        exs_load_data = w_ext;
      end
      default: exs_mem_ready = 1'b1;
    endcase
  end

  assign dmem_req     = (r_state == ST_WAIT);
  assign dmem_we      = dmem_req & r_we;
  assign dmem_addr    = {r_addr[31:2], 2'b00};
  assign dmem_byte_en = r_be;
  assign dmem_w_data  = r_wdata;

endmodule

// File: tb/tb_elbeth_load_store_unit.sv
// Scoreboard bench for elbeth_load_store_unit.
// Timeout shortened to 4 cycles.
module tb_elbeth_load_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        exs_mem_en;
  logic        exs_mem_write;
  logic [1:0]  exs_data_size;
  logic        exs_data_sign;
  logic [31:0] exs_addr;
  logic [31:0] exs_w_data;
  logic        exs_mem_ready;
  logic [31:0] exs_load_data;
  logic        exs_mem_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_byte_en;
  logic [31:0] dmem_w_data;
  logic [31:0] dmem_r_data;
  logic        dmem_ready;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic        load;
    int          ncyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  elbeth_load_store_unit #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .exs_mem_en    (exs_mem_en),
    .exs_mem_write (exs_mem_write),
    .exs_data_size (exs_data_size),
    .exs_data_sign (exs_data_sign),
    .exs_addr      (exs_addr),
    .exs_w_data    (exs_w_data),
    .exs_mem_ready (exs_mem_ready),
    .exs_load_data (exs_load_data),
    .exs_mem_fault (exs_mem_fault),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_byte_en  (dmem_byte_en),
    .dmem_w_data   (dmem_w_data),
    .dmem_r_data   (dmem_r_data),
    .dmem_ready    (dmem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic m_bad(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01) return a[0];
    if (sz == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int k;
    k = int'(a[1:0]);
    if (sz == 2'b00) return 4'(1 << k);
    if (sz == 2'b01) return 4'(3 << k);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (sz == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_ld(
    input logic [31:0] w, input logic [31:0] a,
    input logic [1:0] sz, input logic sg
  );
    logic [31:0] s;
    s = w >> (8 * int'(a[1:0]));
    if (sz == 2'b00) begin
      if (sg && s[7]) return s | 32'hFFFF_FF00;
      return s & 32'h0000_00FF;
    end
    if (sz == 2'b01) begin
      if (sg && s[15]) return s | 32'hFFFF_0000;
      return s & 32'h0000_FFFF;
    end
    return w;
  endfunction

  // lat: WAIT cycle index at which dmem_ready rises; -1 never
  task automatic access(
    input string       nm,
    input logic        we,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          lat
  );
    exp_t e;
    exp_t g;
    int   n;
    int   nreq;
    @(negedge clk);
    exs_mem_en    = 1'b1;
    exs_mem_write = we;
    exs_data_size = sz;
    exs_data_sign = sg;
    exs_addr      = a;
    exs_w_data    = wd;
    dmem_r_data   = rd;
    #1;
    if (m_bad(sz, a)) begin
      chk({nm, "_flt"}, 32'(exs_mem_fault), 32'd1);
      chk({nm, "_rdy"}, 32'(exs_mem_ready), 32'd1);
      chk({nm, "_req"}, 32'(dmem_req), 32'd0);
      @(negedge clk);
      exs_mem_en = 1'b0;
      #1;
      chk({nm, "_req2"}, 32'(dmem_req), 32'd0);
      chk({nm, "_flt2"}, 32'(exs_mem_fault), 32'd0);
      return;
    end
    chk({nm, "_stall"}, 32'(exs_mem_ready), 32'd0);
    e.load  = ~we;
    e.fault = (lat < 0) || (lat >= TO);
    e.data  = e.fault ? 32'd0 : m_ld(rd, a, sz, sg);
    e.ncyc  = e.fault ? TO : lat + 1;
    sb.push_back(e);
    @(negedge clk);
    exs_mem_en = 1'b0;
    n    = 0;
    nreq = 0;
    while (!exs_mem_ready && n < 50) begin
      if (n == 0) begin
        chk({nm, "_addr"}, dmem_addr, {a[31:2], 2'b00});
        chk({nm, "_be"}, 32'(dmem_byte_en), 32'(m_be(sz, a)));
        chk({nm, "_we"}, 32'(dmem_we), 32'(we));
        if (we) chk({nm, "_wd"}, dmem_w_data, m_wd(sz, wd));
      end
      nreq += int'(dmem_req);
      dmem_ready = (n == lat);
      @(negedge clk);
      dmem_ready = 1'b0;
      n++;
    end
    if (n >= 50) begin
      chk({nm, "_hang"}, 32'(n), 32'(e.ncyc));
      g = sb.pop_front();
      return;
    end
    g = sb.pop_front();
    chk({nm, "_lat"}, 32'(n), 32'(g.ncyc));
    chk({nm, "_nreq"}, 32'(nreq), 32'(g.ncyc));
    chk({nm, "_dflt"}, 32'(exs_mem_fault), 32'(g.fault));
    chk({nm, "_dreq"}, 32'(dmem_req), 32'd0);
    if (g.load) chk({nm, "_data"}, exs_load_data, g.data);
    @(negedge clk);
    #1;
    chk({nm, "_idle_rdy"}, 32'(exs_mem_ready), 32'd1);
    chk({nm, "_idle_flt"}, 32'(exs_mem_fault), 32'd0);
  endtask

  initial begin
    rst           = 1'b0;
    exs_mem_en    = 1'b0;
    exs_mem_write = 1'b0;
    exs_data_size = 2'b00;
    exs_data_sign = 1'b0;
    exs_addr      = '0;
    exs_w_data    = '0;
    dmem_r_data   = '0;
    dmem_ready    = 1'b0;
    #1;
    chk("rst_rdy", 32'(exs_mem_ready), 32'd1);
    chk("rst_flt", 32'(exs_mem_fault), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem_byte_en), 32'd0);
    chk("rst_wd", dmem_w_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    access("lw",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    access("lb",   1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 0);
    access("lbu",  1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 1);
    access("sh",   1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 0);
    access("sb",   1'b1, 2'b00, 1'b0, 32'h001, 32'hAA000055, 32'h0, 2);
    access("lh",   1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80011234, 2);
    access("lhu",  1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0000F00D, 0);
    access("lwma", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0);
    access("lhma", 1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 32'h0, 0);
    access("sz11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    access("tout", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h12345678, -1);
    access("edge", 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'hCAFEF00D, TO - 1);

    @(negedge clk);
    exs_mem_en    = 1'b1;
    exs_mem_write = 1'b0;
    exs_data_size = 2'b10;
    exs_addr      = 32'h300;
    @(negedge clk);
    exs_mem_en = 1'b0;
    @(negedge clk);
    chk("mid_req", 32'(dmem_req), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_req), 32'd0);
    chk("arst_rdy", 32'(exs_mem_ready), 32'd1);
    chk("arst_flt", 32'(exs_mem_fault), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    access("post", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0BADF00D, 1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
